seq_mult_hs: RTL and testbench

- Parametrised shift-add sequential multiplier with valid/ready handshakes on operands and product.
- Runtime selection of signed or unsigned operation.
- Successor to the fixed 4-bit free-running multiplier: generalised width, explicit start/done protocol, output backpressure.
- Sits between operand producers and result consumers in datapath blocks that do not need a single-cycle multiply.

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_mult_abs.sv | 17 +
 rtl/seq_mult_hs.sv | 127 ++++++++++++
 tb/tb_seq_mult_hs.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding and a
// constant-evaluable clog2 for deriving counter widths.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Combinational magnitude/sign split of one operand for the sequential multiplier.
// The most negative value maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
module seq_mult_abs #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   input  logic             is_signed,
   output logic [WIDTH-1:0] magnitude,
   output logic             sign
);

   always_comb begin
      sign      = is_signed & value[WIDTH-1];
      magnitude = sign ? ({WIDTH{1'b0}} - value) : value;
   end

endmodule

// File: rtl/seq_mult_hs.sv
// Shift-add sequential multiplier with valid/ready handshakes, signed or unsigned at runtime.
// Define SEQ_MULT_EARLY_TERM_EN to leave BUSY as soon as the remaining multiplier is zero.
module seq_mult_hs
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic                 busy
);

   localparam int CNT_W = clog2(WIDTH + 1);
   localparam int PW    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   state_e           state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [PW-1:0]    p_q, p_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic             a_sgn, b_sgn;
   logic             iter_done;

   seq_mult_abs #(.WIDTH(WIDTH)) u_abs_a (
      .value     (a),
      .is_signed (is_signed),
      .magnitude (a_mag),
      .sign      (a_sgn)
   );

   seq_mult_abs #(.WIDTH(WIDTH)) u_abs_b (
      .value     (b),
      .is_signed (is_signed),
      .magnitude (b_mag),
      .sign      (b_sgn)
   );

   // The exit decision looks at registered state, so the final accumulate lands one edge before p is loaded.
`ifdef SEQ_MULT_EARLY_TERM_EN
   assign iter_done = (cnt_q == CNT_LAST) || ((mplier_q == '0) && (cnt_q != '0));
`else
   assign iter_done = (cnt_q == CNT_LAST);
`endif

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      p_d      = p_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               neg_d    = a_sgn ^ b_sgn;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (iter_done) begin
               p_d     = neg_q ? ({PW{1'b0}} - acc_q) : acc_q;
               state_d = S_DONE;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      p         = p_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         p_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         p_q      <= p_d;
      end
   end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Scoreboard bench for seq_mult_hs: a 4-bit and an 8-bit instance share clock and reset.
module tb_seq_mult_hs;

   logic clk, rst;
   logic iv4, ir4, s4, ov4, ordy4, busy4;
   logic [3:0] a4, b4;
   logic [7:0] p4;
   logic iv8, ir8, s8, ov8, ordy8, busy8;
   logic [7:0] a8, b8;
   logic [15:0] p8;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0]  exp4[$];
   logic [15:0] exp8[$];
   logic [7:0]  e4;
   logic [15:0] e8;
   logic        stall_en;
   int          k;
   logic [7:0]  ra, rb;
   logic        rs;
   logic [15:0] re;
   logic signed [15:0] sa, sb;

`ifdef SEQ_MULT_EARLY_TERM_EN
   localparam int LAT_B1 = 2;
   localparam int LAT_B0 = 2;
`else
   localparam int LAT_B1 = 9;
   localparam int LAT_B0 = 9;
`endif
   localparam int LAT_B80 = 9;

   seq_mult_hs #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .is_signed(s4), .out_valid(ov4), .out_ready(ordy4), .p(p4), .busy(busy4)
   );

   seq_mult_hs #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .is_signed(s8), .out_valid(ov8), .out_ready(ordy8), .p(p8), .busy(busy8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Monitors: pop and compare whenever a product handshake is about to complete.
   always @(negedge clk) begin
      if (rst && ov4 && ordy4) begin
         if (exp4.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL p4_unexpected: actual %0h required no output", p4);
         end else begin
            e4 = exp4.pop_front();
            check("p4", 32'(p4), 32'(e4));
         end
      end
   end

   always @(negedge clk) begin
      if (rst && ov8 && ordy8) begin
         if (exp8.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL p8_unexpected: actual %0h required no output", p8);
         end else begin
            e8 = exp8.pop_front();
            check("p8", 32'(p8), 32'(e8));
         end
      end
   end

   initial begin
      ordy8 = 1'b1;
      forever begin
         @(posedge clk); #2;
         ordy8 = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   task automatic issue4(input logic [3:0] av, input logic [3:0] bv, input logic sg,
                         input logic [7:0] e, input logic push);
      for (int t = 0; t < 200; t++) begin
         @(posedge clk); #2;
         if (ir4) break;
      end
      if (!ir4) begin
         n_cmp++; n_bad++;
         $display("FAIL issue4_timeout: in_ready %0b required 1", ir4);
         return;
      end
      a4 = av; b4 = bv; s4 = sg; iv4 = 1'b1;
      if (push) exp4.push_back(e);
      @(posedge clk); #2;
      iv4 = 1'b0;
   endtask

   task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic sg,
                         input logic [15:0] e);
      for (int t = 0; t < 200; t++) begin
         @(posedge clk); #2;
         if (ir8) break;
      end
      if (!ir8) begin
         n_cmp++; n_bad++;
         $display("FAIL issue8_timeout: in_ready %0b required 1", ir8);
         return;
      end
      a8 = av; b8 = bv; s8 = sg; iv8 = 1'b1;
      exp8.push_back(e);
      @(posedge clk); #2;
      iv8 = 1'b0;
   endtask

   // Counts edges after the input handshake until out_valid is seen high.
   task automatic wait_ov4(output int lat);
      lat = 999;
      for (int i = 2; i <= 100; i++) begin
         @(posedge clk); #1;
         if (ov4) begin lat = i; return; end
      end
   endtask

   task automatic wait_ov8(output int lat);
      lat = 999;
      for (int i = 2; i <= 100; i++) begin
         @(posedge clk); #1;
         if (ov8) begin lat = i; return; end
      end
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 3000; t++) begin
         @(posedge clk); #1;
         if (exp4.size() == 0 && exp8.size() == 0 && ir4 && ir8) return;
      end
      n_cmp++; n_bad++;
      $display("FAIL %s_drain: pending %0d/%0d required 0/0", name, exp4.size(), exp8.size());
   endtask

   initial begin
      rst = 1'b0; stall_en = 1'b0;
      iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; ordy4 = 1'b1;
      iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
      #3;
      check("rst_in_ready4", 32'(ir4), 32'(1));
      check("rst_out_valid4", 32'(ov4), 32'(0));
      check("rst_busy4", 32'(busy4), 32'(0));
      check("rst_p4", 32'(p4), 32'(0));
      check("rst_in_ready8", 32'(ir8), 32'(1));
      check("rst_p8", 32'(p8), 32'(0));
      @(posedge clk); #2;
      rst = 1'b1;

      // The issue task returns 2ns after the handshake edge, so the first edge waited on is N+1.
      issue4(4'd13, 4'd10, 1'b0, 8'd130, 1'b1);
      wait_ov4(k);
      check("lat4_13x10", 32'(k - 1), 32'(5));
      @(posedge clk); #1;
      check("in_ready4_after_out", 32'(ir4), 32'(1));

      issue4(4'b1101, 4'd5, 1'b1, 8'hF1, 1'b1);
      issue4(4'b1000, 4'b1000, 1'b1, 8'h40, 1'b1);
      issue4(4'b1000, 4'b1000, 1'b0, 8'h40, 1'b1);
      issue4(4'd15, 4'd15, 1'b0, 8'hE1, 1'b1);
      issue4(4'b0111, 4'b1000, 1'b1, 8'hC8, 1'b1);
      issue4(4'b1111, 4'b1111, 1'b1, 8'h01, 1'b1);
      issue4(4'd0, 4'b1000, 1'b1, 8'h00, 1'b1);
      drain("dir4");

      // Backpressure: hold the product for 7 cycles while a competing operand is offered.
      @(posedge clk); #2;
      ordy4 = 1'b0;
      issue4(4'd6, 4'd7, 1'b0, 8'h2A, 1'b1);
      wait_ov4(k);
      check("lat4_6x7", 32'(k - 1), 32'(5));
      a4 = 4'd1; b4 = 4'd1; iv4 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("stall_out_valid4", 32'(ov4), 32'(1));
         check("stall_p4", 32'(p4), 32'(8'h2A));
         check("stall_in_ready4", 32'(ir4), 32'(0));
         @(posedge clk); #2;
      end
      iv4 = 1'b0; ordy4 = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready4", 32'(ir4), 32'(1));
      check("bp_out_valid4", 32'(ov4), 32'(0));
      drain("bp4");

      // Abort in the second BUSY cycle; the aborted product is never expected.
      issue4(4'd5, 4'd5, 1'b0, 8'd25, 1'b0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("abort_in_ready4", 32'(ir4), 32'(1));
      check("abort_out_valid4", 32'(ov4), 32'(0));
      check("abort_p4", 32'(p4), 32'(0));
      check("abort_busy4", 32'(busy4), 32'(0));
      @(posedge clk); #2;
      rst = 1'b1;
      issue4(4'd3, 4'd7, 1'b0, 8'd21, 1'b1);
      drain("rst4");

      issue8(8'h5A, 8'h01, 1'b0, 16'h005A);
      wait_ov8(k);
      check("lat8_b01", 32'(k - 1), 32'(LAT_B1));
      issue8(8'h03, 8'h80, 1'b0, 16'h0180);
      wait_ov8(k);
      check("lat8_b80", 32'(k - 1), 32'(LAT_B80));
      issue8(8'h77, 8'h00, 1'b1, 16'h0000);
      wait_ov8(k);
      check("lat8_b00", 32'(k - 1), 32'(LAT_B0));
      issue8(8'h02, 8'hFF, 1'b1, 16'hFFFE);
      wait_ov8(k);
      check("lat8_bneg1", 32'(k - 1), 32'(LAT_B1));

      issue8(8'h80, 8'h80, 1'b1, 16'h4000);
      issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
      issue8(8'h7F, 8'h80, 1'b1, 16'hC080);
      issue8(8'hFF, 8'hFF, 1'b1, 16'h0001);
      issue8(8'h00, 8'h5A, 1'b1, 16'h0000);
      drain("dir8");

      stall_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rs = i[0];
         if (i % 25 == 0) ra = 8'h00;
         if (i % 25 == 7) rb = 8'h00;
         if (rs) begin
            sa = {{8{ra[7]}}, ra};
            sb = {{8{rb[7]}}, rb};
            re = sa * sb;
         end else begin
            re = {8'h00, ra} * {8'h00, rb};
         end
         issue8(ra, rb, rs, re);
      end
      drain("sweep8");
      stall_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
